// File: rtl/multiway_latched_array.sv
// N-way register-file array (tag/valid/dirty/LRU) with shared indices and a self-clearing sweep FSM.
// Optional write-forwarding on same-index read/load: define MULTIWAY_LATCHED_ARRAY_BYPASS_EN.
module multiway_latched_array #(
  parameter int unsigned s_index  = 3,
  parameter int unsigned width    = 1,
  parameter int unsigned num_ways = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  output logic                      ready,
  input  logic                      read,
  input  logic [s_index-1:0]        rindex,
  input  logic [num_ways-1:0]       load,
  input  logic [s_index-1:0]        windex,
  input  logic [width-1:0]          datain,
  output logic [num_ways*width-1:0] dataout,
  output logic                      rvalid
);

  localparam int unsigned num_sets = 1 << s_index;
  localparam int unsigned DW       = num_ways * width;
  localparam logic [s_index-1:0] LAST_IDX = s_index'(num_sets - 1);

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [s_index-1:0]  sweep_idx_q, sweep_idx_d;
  logic                ready_q, ready_d;
  logic                rvalid_q, rvalid_d;
  logic [DW-1:0]       dataout_q, dataout_d;
  logic                sweep_we_c;
  logic                accept_c;

  // Storage: all ways of one set packed together; no reset, the sweep clears it
  logic [DW-1:0]       mem_q [num_sets];

  // Next-state, read path and write strobes
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    rvalid_d    = 1'b0;
    dataout_d   = dataout_q;
    sweep_we_c  = 1'b0;
    accept_c    = 1'b0;

    case (state_q)
      SWEEP: begin
        sweep_we_c = 1'b1;
        if (flush) begin
          sweep_idx_d = '0;
        end else if (sweep_idx_q == LAST_IDX) begin
          state_d     = IDLE;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + s_index'(1);
        end
      end
      IDLE: begin
        accept_c = 1'b1;
        if (flush) begin
          state_d     = SWEEP;
          sweep_idx_d = '0;
        end
      end
      default: begin
        state_d     = SWEEP;
        sweep_idx_d = '0;
      end
    endcase

    ready_d = (state_d == IDLE);

    if (accept_c && read) begin
      rvalid_d = 1'b1;
      for (int unsigned w = 0; w < num_ways; w++) begin
`ifdef MULTIWAY_LATCHED_ARRAY_BYPASS_EN
        if (load[w] && (rindex == windex)) begin
          dataout_d[w*width +: width] = datain;
        end else begin
          dataout_d[w*width +: width] = mem_q[rindex][w*width +: width];
        end
`else
        dataout_d[w*width +: width] = mem_q[rindex][w*width +: width];
`endif
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SWEEP;
      sweep_idx_q <= '0;
      ready_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      dataout_q   <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      ready_q     <= ready_d;
      rvalid_q    <= rvalid_d;
      dataout_q   <= dataout_d;
    end
  end

  // Array writes: sweep clear has priority; user loads only while idle
  always_ff @(posedge clk) begin
    if (sweep_we_c) begin
      mem_q[sweep_idx_q] <= '0;
    end else if (accept_c) begin
      for (int unsigned w = 0; w < num_ways; w++) begin
        if (load[w]) begin
          mem_q[windex][w*width +: width] <= datain;
        end
      end
    end
  end

  assign ready   = ready_q;
  assign rvalid  = rvalid_q;
  assign dataout = dataout_q;

endmodule
